// File: rtl/stream_output_mux.sv
// Per-output data path of the stream crossbar: steers the granted master onto
// the output and holds that selection for a whole packet. The output stage is
// a two-entry (main + skid) register, so the path is fully registered.
module stream_output_mux #(
    parameter int S_DATA_COUNT = 2,
    parameter int T_DATA_WIDTH = 8,
    parameter int T_ID___WIDTH = $clog2(S_DATA_COUNT)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_in,
    input  logic [T_ID___WIDTH-1:0]              id_i,
    output logic [S_DATA_COUNT-1:0]              requests_o,
    output logic [S_DATA_COUNT-1:0]              last_o,
    input  logic [S_DATA_COUNT-1:0]              s_valid_i,
    input  logic [S_DATA_COUNT*T_DATA_WIDTH-1:0] s_data_i,
    input  logic [S_DATA_COUNT-1:0]              s_last_i,
    output logic [S_DATA_COUNT-1:0]              s_ready_o,
    output logic                                 m_valid_o,
    output logic [T_DATA_WIDTH-1:0]              m_data_o,
    output logic                                 m_last_o,
    output logic [T_ID___WIDTH-1:0]              m_id_o,
    input  logic                                 m_ready_i
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state_q, state_d;
    logic [T_ID___WIDTH-1:0] lock_id_q, lock_id_d;
    logic                    in_rdy_q, in_rdy_d;

    logic                    main_valid_q, main_valid_d;
    logic [T_DATA_WIDTH-1:0] main_data_q, main_data_d;
    logic                    main_last_q, main_last_d;
    logic [T_ID___WIDTH-1:0] main_id_q, main_id_d;

    logic                    skid_valid_q, skid_valid_d;
    logic [T_DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                    skid_last_q, skid_last_d;
    logic [T_ID___WIDTH-1:0] skid_id_q, skid_id_d;

    logic [T_ID___WIDTH-1:0] sel;
    logic                    sel_ok;
    logic                    sel_valid;
    logic                    sel_last;
    logic [T_DATA_WIDTH-1:0] sel_data;
    logic                    acc;

    // Select the source (locked id while inside a packet) and derive ready/accept/last
    always_comb begin
        sel        = (state_q == BUSY) ? lock_id_q : id_i;
        sel_ok     = 32'(sel) < 32'(S_DATA_COUNT);
        sel_valid  = 1'b0;
        sel_last   = 1'b0;
        sel_data   = '0;
        s_ready_o  = '0;
        last_o     = '0;
        requests_o = rst_in ? s_valid_i : '0;
        if (sel_ok) begin
            sel_valid      = s_valid_i[sel];
            sel_last       = s_last_i[sel];
            sel_data       = s_data_i[sel*T_DATA_WIDTH +: T_DATA_WIDTH];
            s_ready_o[sel] = in_rdy_q;
        end
        acc = sel_valid && in_rdy_q;
        if (acc && sel_last) begin
            last_o[sel] = 1'b1;
        end
    end

    // Packet lock: enter BUSY on a non-final beat, leave on the final one
    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        case (state_q)
            IDLE: begin
                if (acc && !sel_last) begin
                    state_d   = BUSY;
                    lock_id_d = sel;
                end
            end
            BUSY: begin
                if (acc && sel_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Main/skid output buffer; ready is registered as "skid entry empty"
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_last_d  = main_last_q;
        main_id_d    = main_id_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;
        skid_id_d    = skid_id_q;
        if (main_valid_q && m_ready_i) begin
            if (skid_valid_q) begin
                main_data_d  = skid_data_q;
                main_last_d  = skid_last_q;
                main_id_d    = skid_id_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = 1'b0;
            end
        end
        // A beat is only accepted while skid is empty, so at most one of the
        // two entries is written here and main never receives two beats.
        if (acc) begin
            if (!main_valid_q || m_ready_i) begin
                main_valid_d = 1'b1;
                main_data_d  = sel_data;
                main_last_d  = sel_last;
                main_id_d    = sel;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = sel_data;
                skid_last_d  = sel_last;
                skid_id_d    = sel;
            end
        end
        in_rdy_d = !skid_valid_d;
    end

    // State and buffer registers
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            lock_id_q    <= '0;
            in_rdy_q     <= 1'b0;
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_last_q  <= 1'b0;
            main_id_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_last_q  <= 1'b0;
            skid_id_q    <= '0;
        end else begin
            state_q      <= state_d;
            lock_id_q    <= lock_id_d;
            in_rdy_q     <= in_rdy_d;
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_last_q  <= main_last_d;
            main_id_q    <= main_id_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_last_q  <= skid_last_d;
            skid_id_q    <= skid_id_d;
        end
    end

    assign m_valid_o = main_valid_q;
    assign m_data_o  = main_data_q;
    assign m_last_o  = main_last_q;
    assign m_id_o    = main_id_q;

endmodule

// File: tb/tb_stream_output_mux.sv
// Bench for stream_output_mux: per-master packet sources, a queue-based model
// of the output (2-deep, 1-cycle latency) and a packet-lock model.
module tb_stream_output_mux;

    localparam int N  = 2;
    localparam int W  = 8;
    localparam int IW = 1;

    logic           clk = 1'b0;
    logic           rst_in = 1'b0;
    logic [IW-1:0]  id_i = '0;
    logic [N-1:0]   requests_o, last_o, s_ready_o;
    logic [N-1:0]   s_valid_i = '0;
    logic [N*W-1:0] s_data_i = '0;
    logic [N-1:0]   s_last_i = '0;
    logic           m_valid_o, m_last_o;
    logic [W-1:0]   m_data_o;
    logic [IW-1:0]  m_id_o;
    logic           m_ready_i = 1'b0;

    stream_output_mux #(.S_DATA_COUNT(N), .T_DATA_WIDTH(W), .T_ID___WIDTH(IW)) dut (
        .clk_i(clk), .rst_in(rst_in), .id_i(id_i),
        .requests_o(requests_o), .last_o(last_o),
        .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_last_i(s_last_i),
        .s_ready_o(s_ready_o),
        .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_last_o(m_last_o),
        .m_id_o(m_id_o), .m_ready_i(m_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] d; logic l; } beat_t;
    typedef struct packed { logic [7:0] d; logic l; logic id; } obeat_t;

    beat_t  src0[$];
    beat_t  src1[$];
    obeat_t exp_q[$];

    logic [N-1:0] en = 2'b11;
    logic         mrdy = 1'b1;
    bit           busy = 0;
    logic         lock = 1'b0;
    bit           armed = 0;
    logic         msel;
    logic [N-1:0] rdy_exp;
    bit           acc_exp;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        exp_q.delete();
        busy  = 0;
        lock  = 1'b0;
        armed = 0;
    endtask

    task automatic push_beat(input int m, input logic [7:0] d, input logic l);
        beat_t b;
        b.d = d;
        b.l = l;
        if (m == 0) src0.push_back(b); else src1.push_back(b);
    endtask

    task automatic drive();
        s_valid_i[0] = en[0] && (src0.size() > 0);
        s_valid_i[1] = en[1] && (src1.size() > 0);
        if (src0.size() > 0) {s_data_i[7:0], s_last_i[0]} = {src0[0].d, src0[0].l};
        else {s_data_i[7:0], s_last_i[0]} = 9'($urandom);
        if (src1.size() > 0) {s_data_i[15:8], s_last_i[1]} = {src1[0].d, src1[0].l};
        else {s_data_i[15:8], s_last_i[1]} = 9'($urandom);
        m_ready_i = mrdy;
    endtask

    task automatic check();
        logic [N-1:0] last_exp;
        msel    = busy ? lock : id_i;
        rdy_exp = (rst_in && armed && exp_q.size() <= 1) ? (2'b01 << msel) : 2'b00;
        acc_exp = rdy_exp[msel] && s_valid_i[msel];
        last_exp = (acc_exp && s_last_i[msel]) ? (2'b01 << msel) : 2'b00;
        chk("s_ready", 32'(s_ready_o), 32'(rdy_exp));
        chk("requests", 32'(requests_o), 32'(rst_in ? s_valid_i : 2'b00));
        chk("last_o", 32'(last_o), 32'(last_exp));
        chk("m_valid", 32'(m_valid_o), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            chk("m_data", 32'(m_data_o), 32'(exp_q[0].d));
            chk("m_last", 32'(m_last_o), 32'(exp_q[0].l));
            chk("m_id", 32'(m_id_o), 32'(exp_q[0].id));
        end else if (!rst_in) begin
            chk("rst_m_data", 32'(m_data_o), 32'(0));
            chk("rst_m_last", 32'(m_last_o), 32'(0));
            chk("rst_m_id", 32'(m_id_o), 32'(0));
        end
    endtask

    task automatic update();
        obeat_t o;
        if (!rst_in) begin
            model_reset();
            return;
        end
        if (exp_q.size() > 0 && mrdy) void'(exp_q.pop_front());
        if (acc_exp) begin
            o.d  = msel ? s_data_i[15:8] : s_data_i[7:0];
            o.l  = s_last_i[msel];
            o.id = msel;
            exp_q.push_back(o);
            if (msel) void'(src1.pop_front()); else void'(src0.pop_front());
            if (o.l) busy = 0;
            else if (!busy) begin
                busy = 1;
                lock = msel;
            end
        end
        armed = 1;
    endtask

    task automatic cycle();
        drive();
        #3;
        check();
        @(posedge clk);
        update();
        #1;
    endtask

    task automatic drain(input int maxc);
        int c = 0;
        mrdy = 1'b1;
        en   = 2'b11;
        while ((exp_q.size() > 0 || src0.size() > 0 || src1.size() > 0 || busy) && c < maxc) begin
            if (!busy) id_i = (src0.size() > 0) ? 1'b0 : 1'b1;
            cycle();
            c++;
        end
        chk("drain_in_budget", 32'(c < maxc), 32'(1));
    endtask

    initial begin
        // Reset held for three cycles, then idle with nothing valid
        rst_in = 1'b0;
        repeat (3) cycle();
        rst_in = 1'b1;
        id_i = 1'b0;
        repeat (3) cycle();

        // Single master, 3-beat packet
        push_beat(1, 8'h11, 1'b0);
        push_beat(1, 8'h22, 1'b0);
        push_beat(1, 8'h33, 1'b1);
        drain(20);

        // Grant change mid-packet
        for (int i = 0; i < 4; i++) push_beat(0, 8'hA0 + 8'(i), i == 3);
        push_beat(1, 8'hB0, 1'b1);
        id_i = 1'b0;
        repeat (2) cycle();
        id_i = 1'b1;
        repeat (6) cycle();
        drain(20);

        // Backpressure while streaming
        for (int i = 0; i < 5; i++) push_beat(0, 8'hA0 + 8'(i), i == 4);
        id_i = 1'b0;
        mrdy = 1'b1;
        repeat (2) cycle();
        mrdy = 1'b0;
        repeat (4) cycle();
        drain(20);

        // Single-beat packets with alternating grant
        push_beat(0, 8'h01, 1'b1);
        push_beat(1, 8'h02, 1'b1);
        id_i = 1'b0;
        cycle();
        id_i = 1'b1;
        cycle();
        drain(20);

        // Asynchronous reset between beats 2 and 3 of a 4-beat packet
        for (int i = 0; i < 4; i++) push_beat(0, 8'hC0 + 8'(i), i == 3);
        id_i = 1'b0;
        repeat (2) cycle();
        #1;
        rst_in = 1'b0;
        #1;
        chk("async_rst_m_valid", 32'(m_valid_o), 32'(0));
        chk("async_rst_last_o", 32'(last_o), 32'(0));
        chk("async_rst_s_ready", 32'(s_ready_o), 32'(0));
        model_reset();
        src0.delete();
        src1.delete();
        repeat (2) cycle();
        rst_in = 1'b1;
        push_beat(1, 8'h51, 1'b0);
        push_beat(1, 8'h52, 1'b1);
        id_i = 1'b1;
        drain(20);

        // Randomized traffic: random packets, grant, valid gaps and backpressure
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                int m   = $urandom_range(0, 1);
                int len = $urandom_range(1, 4);
                if ((m == 0 ? src0.size() : src1.size()) < 8)
                    for (int k = 0; k < len; k++) push_beat(m, 8'($urandom), k == len - 1);
            end
            id_i  = 1'($urandom_range(0, 1));
            mrdy  = ($urandom_range(0, 3) != 0);
            en[0] = ($urandom_range(0, 4) != 0);
            en[1] = ($urandom_range(0, 4) != 0);
            cycle();
        end
        drain(100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
